ctrl_pipe: RTL and testbench
============================

CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 The block SHALL have the ports below, one clock domain, clock and reset first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 id_ex_ctrl  input  4  ID-stage EX bundle: [3] RegDst, [2] ALUSrc, [1:0] ALUOp.
REQ-005 id_m_ctrl  input  2  ID-stage MEM bundle: [1] MemRead, [0] MemWrite.
REQ-006 id_wb_ctrl  input  2  ID-stage WB bundle: [1] RegWrite, [0] 1 = ALU result / 0 = memory data.
REQ-007 id_rs, id_rt, id_rd  input  5 each  ID-stage register specifiers.
REQ-008 flush  input  1  branch taken; the instruction in ID is squashed.
REQ-009 hold  input  1  global freeze; all pipeline state holds.
REQ-010 ex_reg_dst, ex_alu_src  output  1 each  EX-stage controls.
REQ-011 ex_alu_op  output  2  EX-stage ALUOp.
REQ-012 mem_read, mem_write  output  1 each  MEM-stage controls.
REQ-013 wb_reg_write, wb_sel_alu  output  1 each  WB-stage controls.
REQ-014 ex_dst, mem_dst, wb_dst  output  5 each  destination register carried with the instruction.
REQ-015 stall  output  1  combinational; 1 = PC and IF/ID SHALL hold this cycle.

Function
REQ-016 Three control registers (ID/EX, EX/MEM, MEM/WB) SHALL advance one stage per cycle when hold=0, giving ID-to-WB latency of 3 cycles.
REQ-017 ID/EX SHALL capture id_ex_ctrl, id_m_ctrl, id_wb_ctrl, id_rt and id_rd; ex_dst SHALL be id_rd-captured when RegDst=1, else id_rt-captured.
REQ-018 Any X bit on the control inputs SHALL be stored as 0.
REQ-019 A bubble SHALL be all control bits 0 and dst 0; it SHALL propagate like an instruction.
REQ-020 stall SHALL be 1 when ID/EX MemRead=1, ID/EX rt != 0, and ID/EX rt equals id_rs or id_rt.
REQ-021 When stall=1 and hold=0, ID/EX SHALL load a bubble while EX/MEM and MEM/WB advance; a load-use pair SHALL lose exactly one cycle.
REQ-022 When flush=1 and hold=0, ID/EX SHALL load a bubble regardless of stall; flush SHALL take priority.
REQ-023 When hold=1, all three registers SHALL keep their values; stall SHALL still be computed from the held state; flush SHALL be ignored.
REQ-024 Priority SHALL be: reset > hold > flush > stall > normal advance.
REQ-025 MEM/WB SHALL capture the EX/MEM WB bundle and mem_dst unchanged; EX/MEM SHALL capture the ID/EX M and WB bundles and ex_dst.

Reset
REQ-026 On reset=1 at a clock edge, every control output and every dst output SHALL be 0 from the next cycle.
REQ-027 Reset SHALL override hold, flush and stall.
REQ-028 Reset asserted mid-stall SHALL leave stall=0 the following cycle.

Configuration
REQ-029 Macro CTRL_PIPE_HAZARD_EN SHALL compile in load-use detection (REQ-020, REQ-021).
REQ-030 Without CTRL_PIPE_HAZARD_EN, stall SHALL be constant 0 and ID/EX SHALL bubble only on flush; all other behaviour SHALL be unchanged.

Verification
REQ-031 R-type (ex 1010, m 00, wb 11, rd=5) then idle -> ex_reg_dst=1 and ex_alu_op=10 at cycle 1, wb_reg_write=1, wb_sel_alu=1 and wb_dst=5 at cycle 3.
REQ-032 LW rt=8 followed by ADD with rs=8 -> stall=1 for exactly one cycle, ID/EX bubble, ADD reaches EX one cycle later (macro defined); with the macro undefined, stall stays 0.
REQ-033 LW rt=0 followed by an instruction with rs=0 -> stall=0.
REQ-034 flush=1 together with a load-use condition -> ID/EX bubble, and older stages advance normally.
REQ-035 hold=1 for 2 cycles mid-stream -> all outputs unchanged for those cycles and resume in order; reset during a stall -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - ID/EX, EX/MEM, MEM/WB control pipeline with load-use stall
// Define CTRL_PIPE_HAZARD_EN to compile in load-use hazard detection.
module ctrl_pipe (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] id_ex_ctrl,
  input  logic [1:0] id_m_ctrl,
  input  logic [1:0] id_wb_ctrl,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_rd,
  input  logic       flush,
  input  logic       hold,
  output logic       ex_reg_dst,
  output logic       ex_alu_src,
  output logic [1:0] ex_alu_op,
  output logic       mem_read,
  output logic       mem_write,
  output logic       wb_reg_write,
  output logic       wb_sel_alu,
  output logic [4:0] ex_dst,
  output logic [4:0] mem_dst,
  output logic [4:0] wb_dst,
  output logic       stall
);

  // Two-state copies turn any unknown control bit into 0 before it is stored.
  bit [3:0] ex_in;
  bit [1:0] m_in;
  bit [1:0] wb_in;
  assign ex_in = id_ex_ctrl;
  assign m_in  = id_m_ctrl;
  assign wb_in = id_wb_ctrl;

  logic [3:0] idex_ex;
  logic [1:0] idex_m;
  logic [1:0] idex_wb;
  logic [4:0] idex_rt;
  logic [4:0] idex_rd;
  logic [1:0] exmem_m;
  logic [1:0] exmem_wb;
  logic [4:0] exmem_dst;
  logic [1:0] memwb_wb;
  logic [4:0] memwb_dst;
  logic       load_use;
  logic       bubble_id;

`ifdef CTRL_PIPE_HAZARD_EN
  assign load_use = idex_m[1] && (idex_rt != 5'd0) &&
                    ((idex_rt == id_rs) || (idex_rt == id_rt));
`else
  logic unused_rs;
  assign unused_rs = ^id_rs;
  assign load_use  = 1'b0;
`endif

  assign stall     = load_use;
  assign bubble_id = flush | load_use;

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_ex   <= '0;
      idex_m    <= '0;
      idex_wb   <= '0;
      idex_rt   <= '0;
      idex_rd   <= '0;
      exmem_m   <= '0;
      exmem_wb  <= '0;
      exmem_dst <= '0;
      memwb_wb  <= '0;
      memwb_dst <= '0;
    end else if (!hold) begin
      if (bubble_id) begin
        idex_ex <= '0;
        idex_m  <= '0;
        idex_wb <= '0;
        idex_rt <= '0;
        idex_rd <= '0;
      end else begin
        idex_ex <= ex_in;
        idex_m  <= m_in;
        idex_wb <= wb_in;
        idex_rt <= id_rt;
        idex_rd <= id_rd;
      end
      exmem_m   <= idex_m;
      exmem_wb  <= idex_wb;
      exmem_dst <= ex_dst;
      memwb_wb  <= exmem_wb;
      memwb_dst <= exmem_dst;
    end
  end

  assign ex_reg_dst   = idex_ex[3];
  assign ex_alu_src   = idex_ex[2];
  assign ex_alu_op    = idex_ex[1:0];
  assign ex_dst       = idex_ex[3] ? idex_rd : idex_rt;
  assign mem_read     = exmem_m[1];
  assign mem_write    = exmem_m[0];
  assign mem_dst      = exmem_dst;
  assign wb_reg_write = memwb_wb[1];
  assign wb_sel_alu   = memwb_wb[0];
  assign wb_dst       = memwb_dst;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - randomized and directed checks of ctrl_pipe against a history model
module tb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] id_ex_ctrl;
  logic [1:0] id_m_ctrl;
  logic [1:0] id_wb_ctrl;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       flush, hold;
  logic       ex_reg_dst, ex_alu_src;
  logic [1:0] ex_alu_op;
  logic       mem_read, mem_write, wb_reg_write, wb_sel_alu;
  logic [4:0] ex_dst, mem_dst, wb_dst;
  logic       stall;

  always #5 clk = ~clk;

  ctrl_pipe dut (
    .clk(clk), .reset(reset),
    .id_ex_ctrl(id_ex_ctrl), .id_m_ctrl(id_m_ctrl), .id_wb_ctrl(id_wb_ctrl),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .flush(flush), .hold(hold),
    .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
    .mem_read(mem_read), .mem_write(mem_write),
    .wb_reg_write(wb_reg_write), .wb_sel_alu(wb_sel_alu),
    .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst),
    .stall(stall)
  );

`ifdef CTRL_PIPE_HAZARD_EN
  localparam bit HAZARD_EN = 1'b1;
`else
  localparam bit HAZARD_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] ex;
    logic [1:0] m;
    logic [1:0] wb;
    logic [4:0] rt;
    logic [4:0] rd;
  } instr_t;

  // Instructions in the order they entered ID/EX; the last three are EX, MEM, WB.
  instr_t hist[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] dst_of(input instr_t i);
    return i.ex[3] ? i.rd : i.rt;
  endfunction

  function automatic logic exp_stall();
    instr_t e;
    e = hist[hist.size()-1];
    return HAZARD_EN && e.m[1] && (e.rt != 5'd0) && (e.rt == id_rs || e.rt == id_rt);
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (3) hist.push_back('0);
  endtask

  task automatic compare_all(input string tag);
    instr_t e, m, w;
    e = hist[hist.size()-1];
    m = hist[hist.size()-2];
    w = hist[hist.size()-3];
    check({tag, "_ex"}, {23'd0, ex_reg_dst, ex_alu_src, ex_alu_op, ex_dst},
          {23'd0, e.ex, dst_of(e)});
    check({tag, "_mem"}, {25'd0, mem_read, mem_write, mem_dst}, {25'd0, m.m, dst_of(m)});
    check({tag, "_wb"}, {25'd0, wb_reg_write, wb_sel_alu, wb_dst}, {25'd0, w.wb, dst_of(w)});
    check({tag, "_stall"}, {31'd0, stall}, {31'd0, exp_stall()});
  endtask

  // Drive one ID-stage cycle, check outputs before the edge, then advance the model.
  task automatic step(input string tag, input logic [3:0] exc, input logic [1:0] mc,
                      input logic [1:0] wbc, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic fl, input logic hd, input logic rst);
    instr_t n;
    logic   st;
    id_ex_ctrl = exc; id_m_ctrl = mc; id_wb_ctrl = wbc;
    id_rs = rs; id_rt = rt; id_rd = rd;
    flush = fl; hold = hd; reset = rst;
    #1;
    compare_all(tag);
    st = exp_stall();
    @(posedge clk);
    if (rst) model_reset();
    else if (!hd) begin
      n = (fl || st) ? '0 : instr_t'{exc, mc, wbc, rt, rd};
      hist.push_back(n);
      void'(hist.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    step(tag, 4'h0, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int stalls;
    reset = 1'b1; flush = 1'b0; hold = 1'b0;
    id_ex_ctrl = '0; id_m_ctrl = '0; id_wb_ctrl = '0;
    id_rs = '0; id_rt = '0; id_rd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    check("reset_outs", {16'd0, ex_reg_dst, ex_alu_src, ex_alu_op, mem_read, mem_write,
          wb_reg_write, wb_sel_alu, ex_dst, mem_dst, wb_dst, stall}, 32'd0);

    // R-type rd=5, then idle
    step("rtype", 4'b1010, 2'b00, 2'b11, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0);
    #1;
    check("rtype_c1", {29'd0, ex_reg_dst, ex_alu_op}, {29'd0, 1'b1, 2'b10});
    idle("rt_i1");
    idle("rt_i2");
    #1;
    check("rtype_c3", {25'd0, wb_reg_write, wb_sel_alu, wb_dst}, {25'd0, 2'b11, 5'd5});

    // LW rt=8 then ADD rs=8; ADD re-presented while stalled
    step("lw", 4'b0100, 2'b10, 2'b10, 5'd3, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (!stall) break;
      stalls++;
      step("add_st", 4'b1010, 2'b00, 2'b11, 5'd8, 5'd9, 5'd10, 1'b0, 1'b0, 1'b0);
    end
    check("lu_stall_cycles", stalls, HAZARD_EN ? 1 : 0);
    step("add", 4'b1010, 2'b00, 2'b11, 5'd8, 5'd9, 5'd10, 1'b0, 1'b0, 1'b0);
    #1;
    check("add_in_ex", {26'd0, ex_reg_dst, ex_dst}, {26'd0, 1'b1, 5'd10});
    idle("lu_i");

    // LW rt=0 never stalls
    step("lw0", 4'b0100, 2'b10, 2'b10, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("use0", 4'b1010, 2'b00, 2'b11, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0);

    // flush with load-use pending
    step("lw_f", 4'b0100, 2'b10, 2'b10, 5'd3, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0);
    step("flush", 4'b1010, 2'b00, 2'b11, 5'd7, 5'd7, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    check("flush_bubble", {23'd0, ex_reg_dst, ex_alu_src, ex_alu_op, ex_dst}, 32'd0);
    check("flush_mem_adv", {31'd0, mem_read}, 32'd1);

    // hold two cycles mid-stream
    step("h_a", 4'b1110, 2'b01, 2'b11, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
    step("h_b", 4'b0101, 2'b00, 2'b10, 5'd4, 5'd5, 5'd6, 1'b0, 1'b0, 1'b0);
    step("hold1", 4'b1111, 2'b11, 2'b11, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0);
    step("hold2", 4'b1111, 2'b11, 2'b11, 5'd9, 5'd9, 5'd9, 1'b0, 1'b1, 1'b0);
    idle("h_r1");
    idle("h_r2");

    // reset during a stall
    step("lw_r", 4'b0100, 2'b10, 2'b10, 5'd3, 5'd12, 5'd0, 1'b0, 1'b0, 1'b0);
    step("rst_st", 4'b1010, 2'b00, 2'b11, 5'd12, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1);
    id_rs = 5'd12;
    #1;
    check("rst_outs", {16'd0, ex_reg_dst, ex_alu_src, ex_alu_op, mem_read, mem_write,
          wb_reg_write, wb_sel_alu, ex_dst, mem_dst, wb_dst, stall}, 32'd0);

    // randomized stream; small register range makes hazards frequent
    for (int i = 0; i < 400; i++) begin
      step("rnd", 4'($urandom), 2'($urandom), 2'($urandom),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 60) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
